spi_frame_sequencer: RTL and testbench

Command-level controller between the SPI byte receiver and the dithering datapath. Parses byte streams framed by chip-select into commands:
- Write pixels into the frame buffer.
- Launch the Floyd-Steinberg engine.
- Return a status byte to the SPI transmit side.

---
 rtl/spi_frame_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// SPI command sequencer: decodes chip-select framed byte streams into pixel writes,
// dither start and status reads. Optional FRAME_CHECKSUM_EN adds an XOR pixel checksum.
module spi_frame_sequencer #(
    parameter int         ADDR_W    = 14,
    parameter int         FB_DEPTH  = 16384,
    parameter logic [7:0] OP_WRITE  = 8'hA1,
    parameter logic [7:0] OP_START  = 8'hB2,
    parameter logic [7:0] OP_STATUS = 8'hC3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_active,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [7:0]        fb_wr_data,
    output logic              dith_start,
    input  logic              dith_busy,
    input  logic              dith_done,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [7:0]        status
);

    // state     | meaning
    // S_IDLE    | chip-select inactive, waiting for it to rise
    // S_OPCODE  | waiting for the command byte
    // S_ADDR_HI | waiting for start address high byte
    // S_ADDR_LO | waiting for start address low byte
    // S_WRITE   | every byte is a pixel written at the running address
    // S_STATUS  | status byte returned, trailing bytes answered
    // S_DISCARD | ignore bytes until chip-select falls
    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR_HI, S_ADDR_LO, S_WRITE, S_STATUS, S_DISCARD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t            state_q, state_d;
    logic              cs_q, cs_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_opc_q, err_opc_d;
    logic              err_busy_q, err_busy_d;
    logic              wrap_q, wrap_d;
    logic              fb_wr_en_q, fb_wr_en_d;
    logic [ADDR_W-1:0] fb_wr_addr_q, fb_wr_addr_d;
    logic [7:0]        fb_wr_data_q, fb_wr_data_d;
    logic              dith_start_q, dith_start_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
    logic [ADDR_W-1:0] addr_start;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              csum_sent_q, csum_sent_d;
`endif

    assign status     = {dith_busy, done_q, err_opc_q, err_busy_q, wrap_q, 3'b000};
    assign addr_start = ADDR_W'({addr_hi_q, rx_byte});

    always_comb begin
        state_d      = state_q;
        cs_d         = cs_active;
        addr_hi_d    = addr_hi_q;
        addr_d       = addr_q;
        done_d       = done_q;
        err_opc_d    = err_opc_q;
        err_busy_d   = err_busy_q;
        wrap_d       = wrap_q;
        fb_wr_en_d   = 1'b0;
        fb_wr_addr_d = fb_wr_addr_q;
        fb_wr_data_d = fb_wr_data_q;
        dith_start_d = 1'b0;
        tx_byte_d    = tx_byte_q;
        tx_load_d    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
        csum_sent_d  = csum_sent_q;
`endif
        // Chip-select low ends any frame; a byte arriving on that cycle is dropped.
        if (!cs_active && state_q != S_IDLE) begin
            state_d = S_IDLE;
            if (state_q == S_STATUS) begin
                err_opc_d  = 1'b0;
                err_busy_d = 1'b0;
                wrap_d     = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (cs_active && !cs_q) state_d = S_OPCODE;
                S_OPCODE: if (rx_valid) begin
                    if (rx_byte == OP_WRITE) begin
                        if (dith_busy) begin
                            err_busy_d = 1'b1;
                            state_d    = S_DISCARD;
                        end else begin
                            state_d = S_ADDR_HI;
`ifdef FRAME_CHECKSUM_EN
                            csum_d  = 8'h00;
`endif
                        end
                    end else if (rx_byte == OP_START) begin
                        if (dith_busy) err_busy_d = 1'b1;
                        else begin
                            dith_start_d = 1'b1;
                            done_d       = 1'b0;
                        end
                        state_d = S_DISCARD;
                    end else if (rx_byte == OP_STATUS) begin
                        tx_byte_d = status;
                        tx_load_d = 1'b1;
                        state_d   = S_STATUS;
`ifdef FRAME_CHECKSUM_EN
                        csum_sent_d = 1'b0;
`endif
                    end else begin
                        err_opc_d = 1'b1;
                        state_d   = S_DISCARD;
                    end
                end
                S_ADDR_HI: if (rx_valid) begin
                    addr_hi_d = rx_byte;
                    state_d   = S_ADDR_LO;
                end
                S_ADDR_LO: if (rx_valid) begin
                    if (32'(addr_start) >= 32'(FB_DEPTH)) begin
                        addr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_start;
                    end
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (dith_busy) begin
                        err_busy_d = 1'b1;
                        state_d    = S_DISCARD;
                    end else if (rx_valid) begin
                        fb_wr_en_d   = 1'b1;
                        fb_wr_addr_d = addr_q;
                        fb_wr_data_d = rx_byte;
`ifdef FRAME_CHECKSUM_EN
                        csum_d       = csum_q ^ rx_byte;
`endif
                        if (addr_q == LAST_ADDR) begin
                            addr_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_STATUS: if (rx_valid) begin
                    tx_load_d = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    tx_byte_d   = csum_sent_q ? 8'h00 : csum_q;
                    csum_sent_d = 1'b1;
`else
                    tx_byte_d   = 8'h00;
`endif
                end
                default: ;
            endcase
        end
        // Completion wins over the clear done by a coincident start.
        if (dith_done) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cs_q         <= 1'b0;
            addr_hi_q    <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            err_opc_q    <= 1'b0;
            err_busy_q   <= 1'b0;
            wrap_q       <= 1'b0;
            fb_wr_en_q   <= 1'b0;
            fb_wr_addr_q <= '0;
            fb_wr_data_q <= '0;
            dith_start_q <= 1'b0;
            tx_byte_q    <= '0;
            tx_load_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= '0;
            csum_sent_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            addr_hi_q    <= addr_hi_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
            err_opc_q    <= err_opc_d;
            err_busy_q   <= err_busy_d;
            wrap_q       <= wrap_d;
            fb_wr_en_q   <= fb_wr_en_d;
            fb_wr_addr_q <= fb_wr_addr_d;
            fb_wr_data_q <= fb_wr_data_d;
            dith_start_q <= dith_start_d;
            tx_byte_q    <= tx_byte_d;
            tx_load_q    <= tx_load_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_sent_q  <= csum_sent_d;
`endif
        end
    end

    assign fb_wr_en   = fb_wr_en_q;
    assign fb_wr_addr = fb_wr_addr_q;
    assign fb_wr_data = fb_wr_data_q;
    assign dith_start = dith_start_q;
    assign tx_byte    = tx_byte_q;
    assign tx_load    = tx_load_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Testbench for spi_frame_sequencer: table of whole frames plus hand-written corner sequences.
module tb_spi_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_active = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        dith_busy = 1'b0;
    logic        dith_done = 1'b0;
    logic        fb_wr_en;
    logic [13:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;
    logic        dith_start;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [7:0]  status;

    spi_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data), .dith_start(dith_start), .dith_busy(dith_busy),
        .dith_done(dith_done), .tx_byte(tx_byte), .tx_load(tx_load), .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int lat_err = 0;
    logic rv_s = 1'b0;
    logic [13:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  tq[$];

    always @(posedge clk) rv_s <= rx_valid;

    // Every output strobe must follow an rx_valid seen on the previous edge.
    always @(negedge clk) begin
        if (fb_wr_en) begin
            wa.push_back(fb_wr_addr);
            wd.push_back(fb_wr_data);
            if (!rv_s) lat_err++;
        end
        if (tx_load) begin
            tq.push_back(tx_byte);
            if (!rv_s) lat_err++;
        end
        if (dith_start) start_cnt++;
    end

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic        busy;
        int          exp_wr;
        logic [13:0] a0;
        int          exp_start;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int tq_get(input int i);
        return (tq.size() > i) ? int'(tq[i]) : -1;
    endfunction

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        tq.delete();
        start_cnt = 0;
    endtask

    task automatic cs_on();
        @(posedge clk); #1 cs_active = 1'b1;
        @(posedge clk);
    endtask

    task automatic cs_off();
        @(posedge clk); #1 cs_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_byte = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [47:0] bytes, input int n);
        cs_on();
        for (int i = 0; i < n; i++) send(bytes[47-8*i -: 8]);
        cs_off();
    endtask

    task automatic status_read();
        clear_mon();
        frame(48'hC3_00_00_00_00_00, 1);
    endtask

    initial begin
        logic [47:0] bb;
        logic [13:0] a;
        logic [7:0]  csum_exp;

        vecs[0] = '{48'hA1_00_10_11_22_33, 6, 1'b0, 3, 14'h0010, 0, 8'h00};
        vecs[1] = '{48'hA1_3F_FF_AA_BB_00, 5, 1'b0, 2, 14'h3FFF, 0, 8'h08};
        vecs[2] = '{48'hA1_00_10_55_00_00, 4, 1'b1, 0, 14'h0000, 0, 8'h90};
        vecs[3] = '{48'h5E_01_02_03_04_00, 5, 1'b0, 0, 14'h0000, 0, 8'h20};
        vecs[4] = '{48'hA1_00_20_77_00_00, 4, 1'b0, 1, 14'h0020, 0, 8'h00};
        vecs[5] = '{48'hA1_FF_FF_01_00_00, 4, 1'b0, 1, 14'h3FFF, 0, 8'h08};
        vecs[6] = '{48'hA1_40_05_99_00_00, 4, 1'b0, 1, 14'h0005, 0, 8'h00};
        vecs[7] = '{48'hB2_00_00_00_00_00, 1, 1'b1, 0, 14'h0000, 0, 8'h90};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_fb_wr_en", int'(fb_wr_en), 0);
        chk("reset_fb_wr_addr", int'(fb_wr_addr), 0);
        chk("reset_dith_start", int'(dith_start), 0);
        chk("reset_tx", int'({tx_load, tx_byte}), 0);
        chk("reset_status", int'(status), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            dith_busy = vecs[v].busy;
            clear_mon();
            frame(vecs[v].bytes, vecs[v].n);
            chk($sformatf("v%0d_wr_count", v), wa.size(), vecs[v].exp_wr);
            bb = vecs[v].bytes;
            a  = vecs[v].a0;
            for (int k = 0; k < vecs[v].exp_wr && k < wa.size(); k++) begin
                chk($sformatf("v%0d_wr%0d_addr", v, k), int'(wa[k]), int'(a));
                chk($sformatf("v%0d_wr%0d_data", v, k), int'(wd[k]), int'(bb[47-8*(3+k) -: 8]));
                a = (a == 14'h3FFF) ? 14'h0000 : a + 14'h0001;
            end
            chk($sformatf("v%0d_no_tx", v), tq.size(), 0);
            chk($sformatf("v%0d_start_cnt", v), start_cnt, vecs[v].exp_start);
            chk($sformatf("v%0d_status", v), int'(status), int'(vecs[v].exp_status));
            status_read();
            chk($sformatf("v%0d_rd_count", v), tq.size(), 1);
            chk($sformatf("v%0d_rd_byte", v), tq_get(0), int'(vecs[v].exp_status));
            dith_busy = 1'b0;
            #1;
            chk($sformatf("v%0d_cleared", v), int'(status), 0);
        end

        // Start, later completion, done_sticky survives a status read, next start clears it.
        clear_mon();
        frame(48'hB2_00_00_00_00_00, 1);
        chk("start_pulse_cnt", start_cnt, 1);
        chk("start_done_low", int'(status), 0);
        repeat (50) @(posedge clk);
        #1 dith_done = 1'b1;
        @(posedge clk); #1 dith_done = 1'b0;
        chk("done_sticky_set", int'(status), 8'h40);
        status_read();
        chk("done_rd_byte", tq_get(0), 8'h40);
        chk("done_kept", int'(status), 8'h40);
        clear_mon();
        frame(48'hB2_00_00_00_00_00, 1);
        chk("restart_pulse_cnt", start_cnt, 1);
        chk("restart_done_clr", int'(status), 0);

        // Engine grabs memory mid-frame.
        clear_mon();
        cs_on();
        send(8'hA1); send(8'h00); send(8'h00); send(8'h11);
        @(posedge clk); #1 dith_busy = 1'b1;
        send(8'h22);
        cs_off();
        chk("midbusy_wr_count", wa.size(), 1);
        chk("midbusy_wr_data", wd.size() > 0 ? int'(wd[0]) : -1, 8'h11);
        chk("midbusy_status", int'(status), 8'h90);
        dith_busy = 1'b0;
        status_read();
        chk("midbusy_rd_byte", tq_get(0), 8'h10);
        chk("midbusy_cleared", int'(status), 0);

        // Byte coinciding with chip-select fall is dropped.
        clear_mon();
        cs_on();
        send(8'hA1); send(8'h00); send(8'h30);
        @(posedge clk); #1 rx_byte = 8'h44; rx_valid = 1'b1; cs_active = 1'b0;
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("csfall_no_write", wa.size(), 0);
        chk("csfall_status", int'(status), 0);

        // Reset mid-frame: no write may follow.
        clear_mon();
        cs_on();
        send(8'hA1); send(8'h00); send(8'h00);
        @(posedge clk); #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        send(8'h55);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_no_write", wa.size(), 0);
        cs_off();
        status_read();

        // Checksum (or zero filler) after the status byte.
        clear_mon();
        frame(48'hA1_00_00_0F_F0_00, 5);
        chk("csum_wr_count", wa.size(), 2);
        clear_mon();
        cs_on();
        send(8'hC3); send(8'h12); send(8'h34);
        cs_off();
`ifdef FRAME_CHECKSUM_EN
        csum_exp = 8'hFF;
`else
        csum_exp = 8'h00;
`endif
        chk("csum_tx_count", tq.size(), 3);
        chk("csum_tx0_status", tq_get(0), 8'h00);
        chk("csum_tx1", tq_get(1), int'(csum_exp));
        chk("csum_tx2", tq_get(2), 8'h00);

        chk("strobe_latency", lat_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
